pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the single-issue core.
- Runs one program from START_ADDR until a halt instruction, then raises Done.
- Takes the branch target already resolved by the branch-target LUT.
- Applies relative (signed offset) or absolute redirects and inserts a one-cycle fetch bubble after each taken branch.
- Counts retired instructions for the test harness.

Parameters:
- D, 12, PC width in bits; instruction memory depth is 2^D.
- START_ADDR, 0, PC value loaded on Reset and on each Start.
- CW, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high; overrides all other inputs.
- Start  input  1  level; begins a program run from IDLE or DONE.
- Stall  input  1  freezes PC, state and counter while in RUN.
- Halt  input  1  decoded halt for the instruction at current PC.
- BranchEn  input  1  decoded branch with condition true for the instruction at PC.
- AbsJump  input  1  when 1, Target is an absolute address; when 0, Target is a signed two's-complement offset.
- Target  input  D  resolved target from the branch LUT.
- PC  output  D  current fetch address (registered).
- FetchValid  output  1  instruction at PC is valid to execute this cycle.
- Flush  output  1  high during the bubble cycle after a taken branch.
- Done  output  1  program halted; held until restart or Reset.
- InstCount  output  CW  instructions retired in the current run.

Behaviour:
- States: IDLE, RUN, FLUSH, DONE. All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.
- Reset (sync, any state, including mid-run or mid-FLUSH) -> next cycle:
  - state IDLE, PC=START_ADDR, InstCount=0;
  - FetchValid=0, Flush=0, Done=0.
- IDLE:
  - FetchValid=0.
  - Start=1 -> RUN; PC=START_ADDR; InstCount=0.
  - Otherwise hold.
- RUN:
  - FetchValid=1.
  - Priority per cycle: Stall > Halt > BranchEn > sequential.
  - Stall=1: PC, InstCount and state hold; Halt and BranchEn are ignored.
  - Halt=1: -> DONE. PC holds at the halt address. InstCount+1, because the halt itself retires.
  - BranchEn=1:
    - AbsJump=1: PC <= Target.
    - AbsJump=0: PC <= PC + sign-extended Target, modulo 2^D.
    - InstCount+1; -> FLUSH.
  - Otherwise: PC <= PC+1 modulo 2^D (2^D-1 wraps to 0); InstCount+1.
  - A relative Target of 0 is legal: PC keeps the same value, a FLUSH is still taken, and the branch counts.
- FLUSH:
  - Exactly one cycle; FetchValid=0, Flush=1.
  - Halt, BranchEn and Stall are all ignored; PC holds the new target.
  - -> RUN unconditionally.
- DONE:
  - Done=1, FetchValid=0; PC holds.
  - Start=1 -> RUN; PC=START_ADDR; InstCount=0; Done drops in that same transition.
  - Start held high continuously after a restart does not re-trigger a restart while in RUN.
- InstCount saturates at 2^CW-1 and never wraps.
- Latency:
  - Start sampled in IDLE -> first FetchValid=1 on the next cycle.
  - Taken branch -> target fetched 2 cycles after the branch cycle.
- Start in RUN or FLUSH is ignored.

Test Plan:
- Reset, Start=1 for 1 cycle, no branches, Halt at PC=5 -> PC runs 0,1,2,3,4,5. Done=1 the cycle after PC=5, PC stays 5, InstCount=6.
- At PC=3: BranchEn=1, AbsJump=0, Target=12'hFFE (-2) -> next cycle Flush=1, FetchValid=0, PC=1. Following cycle FetchValid=1, PC=1. InstCount counts the branch once.
- At PC=7: BranchEn=1, AbsJump=1, Target=40 -> FLUSH, then RUN at PC=40. Next, Stall=1 for 3 cycles with Halt=1 -> PC stays 40, InstCount frozen, no DONE. Stall then drops -> DONE.
- START_ADDR=0, D=4, sequential run to PC=15 -> next PC=0 (wrap). With CW=3, InstCount saturates at 7.
- Reset asserted during FLUSH after a taken branch -> next cycle IDLE, PC=START_ADDR, Flush=0, InstCount=0. A later Start restarts cleanly.
- In DONE with InstCount=9: Start=1 -> RUN, PC=START_ADDR, InstCount=0, Done=0 on the same edge. Start asserted during RUN has no effect.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the single-issue core.
// Runs one program from START_ADDR until halt, inserting a single bubble
// cycle after every taken branch and counting retired instructions.
module pc_sequencer #(
  parameter int               D          = 12,
  parameter logic [D-1:0]     START_ADDR = '0,
  parameter int               CW         = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          BranchEn,
  input  logic          AbsJump,
  input  logic [D-1:0]  Target,
  output logic [D-1:0]  PC,
  output logic          FetchValid,
  output logic          Flush,
  output logic          Done,
  output logic [CW-1:0] InstCount
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [D-1:0]  PC_ONE  = D'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nx;
  logic [D-1:0]  pc_q, pc_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [CW-1:0] cnt_sat;

  // Retire counter sticks at all-ones instead of wrapping.
  assign cnt_sat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // State, PC and counter registers; Reset wins over everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      pc_q  <= START_ADDR;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      pc_q  <= pc_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Next-state: Stall > Halt > BranchEn > sequential while running.
  // Relative targets are D-bit two's complement, so a plain D-bit add
  // is the sign-extended add modulo 2^D.
  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nx = RUN;
          pc_nx    = START_ADDR;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (!Stall) begin
          cnt_nx = cnt_sat;
          if (Halt) begin
            state_nx = DONE;
          end else if (BranchEn) begin
            state_nx = FLUSH;
            pc_nx    = AbsJump ? Target : pc_q + Target;
          end else begin
            pc_nx = pc_q + PC_ONE;
          end
        end
      end
      FLUSH: state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs come only from registered state, never from inputs.
  assign PC         = pc_q;
  assign InstCount  = cnt_q;
  assign FetchValid = (state == RUN);
  assign Flush      = (state == FLUSH);
  assign Done       = (state == DONE);

endmodule
